// File: rtl/rr_arbiter_8_if.sv
// rtl/rr_arbiter_8_if.sv - request/grant bundle between the eight sources, the arbiter and the 8:1 mux
//
// Signals:
//   req          sources -> arbiter   one request bit per source
//   ack          consumer -> arbiter  muxed word consumed
//   selector     arbiter -> mux       index of granted source
//   grant        arbiter -> sources   one-hot copy of selector, zero when idle
//   grant_valid  arbiter -> all       selector/grant valid
//   timeout      arbiter -> all       one-cycle watchdog pulse
// Modports: master = requester/consumer side, slave = arbiter side.

interface rr_arbiter_8_if #(
  parameter int N     = 8,
  parameter int SEL_W = 3
);
  logic [N-1:0]     req;
  logic             ack;
  logic [SEL_W-1:0] selector;
  logic [N-1:0]     grant;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req, ack,
    input  selector, grant, grant_valid, timeout
  );

  modport slave (
    input  req, ack,
    output selector, grant, grant_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - round-robin arbiter driving the 3-bit selector of the 16-bit 8:1 data mux
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_arbiter_8_if.slave: req/ack in, selector/grant/grant_valid/timeout out
// All outputs are registered. A grant is held until ack or until the watchdog
// drops it after TIMEOUT unacknowledged cycles.

module rr_arbiter_8 #(
  parameter int N       = 8,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_8_if.slave  bus
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state;
  logic [SEL_W-1:0] ptr;
  logic [CNT_W-1:0] cnt;

  logic [SEL_W-1:0] next_base;
  logic [SEL_W-1:0] idx_idle;
  logic [SEL_W-1:0] idx_next;
  logic             idle_hit;
  logic [SEL_W-1:0] idle_win;
  logic             next_hit;
  logic [SEL_W-1:0] next_win;

  // Two searches run in parallel: one from ptr (used from IDLE) and one from
  // selector+1 (used on ack, so a back-to-back grant sees the updated pointer
  // in the same edge). Scanning from the farthest offset down lets the
  // nearest requester overwrite, giving first-set-bit priority without a break.
  always_comb begin
    next_base = bus.selector + SEL_W'(1);
    idx_idle  = '0;
    idx_next  = '0;
    idle_hit  = 1'b0;
    idle_win  = '0;
    next_hit  = 1'b0;
    next_win  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx_idle = ptr + SEL_W'(i);
      idx_next = next_base + SEL_W'(i);
      if (bus.req[idx_idle]) begin
        idle_hit = 1'b1;
        idle_win = idx_idle;
      end
      if (bus.req[idx_next]) begin
        next_hit = 1'b1;
        next_win = idx_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      ptr             <= '0;
      cnt             <= '0;
      bus.selector    <= '0;
      bus.grant       <= '0;
      bus.grant_valid <= 1'b0;
      bus.timeout     <= 1'b0;
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_hit) begin
            bus.selector    <= idle_win;
            bus.grant       <= N'(1) << idle_win;
            bus.grant_valid <= 1'b1;
            cnt             <= '0;
            state           <= GRANT;
          end
        end
        GRANT: begin
          if (bus.ack) begin
            // ack has priority over a watchdog expiry on the same edge
            ptr <= next_base;
            cnt <= '0;
            if (next_hit) begin
              bus.selector <= next_win;
              bus.grant    <= N'(1) << next_win;
            end else begin
              bus.grant       <= '0;
              bus.grant_valid <= 1'b0;
              state           <= IDLE;
            end
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            // Dropped grant still advances the pointer so a stuck source
            // cannot monopolise the mux; no re-grant on this edge.
            ptr             <= next_base;
            cnt             <= '0;
            bus.grant       <= '0;
            bus.grant_valid <= 1'b0;
            bus.timeout     <= 1'b1;
            state           <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed and randomized bench for rr_arbiter_8 with a transaction-level model

module tb_rr_arbiter_8;

  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rr_arbiter_8_if bus_if ();

  rr_arbiter_8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: who holds the mux, for how many cycles, and where the
  // fairness pointer stands.
  int         m_ptr;
  int         m_sel;
  int         m_age;
  bit         m_valid;
  bit         m_to;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int find_winner(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) begin
      if (r[(p + k) % 8]) return (p + k) % 8;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_sel = 0; m_age = 0; m_valid = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic a);
    int w;
    m_to = 0;
    if (!m_valid) begin
      w = find_winner(r, m_ptr);
      if (w >= 0) begin m_sel = w; m_valid = 1; m_age = 1; end
    end else if (a) begin
      m_ptr = (m_sel + 1) % 8;
      w = find_winner(r, m_ptr);
      if (w >= 0) begin m_sel = w; m_age = 1; end
      else m_valid = 0;
    end else if (m_age == TIMEOUT) begin
      m_ptr = (m_sel + 1) % 8;
      m_valid = 0;
      m_to = 1;
    end else begin
      m_age++;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [7:0] exp_grant;
    exp_grant = m_valid ? (8'd1 << m_sel) : 8'd0;
    check({tag, ".selector"}, 32'(bus_if.selector), 32'(m_sel));
    check({tag, ".grant"}, 32'(bus_if.grant), 32'(exp_grant));
    check({tag, ".grant_valid"}, 32'(bus_if.grant_valid), 32'(m_valid));
    check({tag, ".timeout"}, 32'(bus_if.timeout), 32'(m_to));
  endtask

  task automatic cycle(input string tag, input logic [7:0] r, input logic a);
    bus_if.req = r;
    bus_if.ack = a;
    model_edge(r, a);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
    #1;
    check_outputs("reset");
    rst_n = 1'b1;
  endtask

  initial begin
    int held;
    bit seen;
    logic [7:0] r;
    logic a;
    bus_if.req = 8'h00;
    bus_if.ack = 1'b0;

    // 1: reset, then idle for 10 cycles
    do_reset(3);
    for (int i = 0; i < 10; i++) cycle("idle", 8'h00, 1'b0);

    // 2: single request, ack two cycles after grant
    cycle("single_grant", 8'h20, 1'b0);
    check("single_sel5", 32'(bus_if.selector), 32'd5);
    check("single_grant20", 32'(bus_if.grant), 32'h20);
    cycle("single_hold", 8'h20, 1'b0);
    cycle("single_hold", 8'h20, 1'b0);
    cycle("single_ack", 8'h00, 1'b1);
    check("single_released", 32'(bus_if.grant_valid), 32'd0);

    // 4: wrap and skip from ptr=6
    cycle("wrap", 8'h05, 1'b0);
    check("wrap_sel0", 32'(bus_if.selector), 32'd0);
    cycle("skip", 8'h05, 1'b1);
    check("skip_sel2", 32'(bus_if.selector), 32'd2);
    cycle("sole_regrant", 8'h04, 1'b1);
    check("sole_regrant_sel2", 32'(bus_if.selector), 32'd2);
    check("sole_regrant_valid", 32'(bus_if.grant_valid), 32'd1);
    cycle("drop", 8'h00, 1'b1);

    // 3: rotation from ptr=0
    do_reset(2);
    cycle("rot_first", 8'hFF, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cycle("rot", 8'hFF, 1'b1);
      check("rot_seq", 32'(bus_if.selector), 32'(k % 8));
      check("rot_valid", 32'(bus_if.grant_valid), 32'd1);
    end
    cycle("rot_drop", 8'h00, 1'b1);

    // 5: watchdog
    do_reset(2);
    cycle("wd_grant", 8'h08, 1'b0);
    held = 1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      cycle("wd_wait", 8'h08, 1'b0);
      if (bus_if.timeout === 1'b1) begin seen = 1; break; end
      if (bus_if.grant_valid === 1'b1) held++;
    end
    check("wd_pulse_seen", 32'(seen), 32'd1);
    check("wd_held_cycles", 32'(held), 32'(TIMEOUT));
    check("wd_grant_zero", 32'(bus_if.grant), 32'h00);
    cycle("wd_after", 8'h09, 1'b0);
    check("wd_wrap_sel0", 32'(bus_if.selector), 32'd0);
    check("wd_pulse_one_cycle", 32'(bus_if.timeout), 32'd0);
    cycle("wd_next", 8'h09, 1'b1);
    cycle("wd_sole3", 8'h08, 1'b1);
    check("wd_sole3_sel", 32'(bus_if.selector), 32'd3);
    cycle("wd_drop", 8'h00, 1'b1);

    // 6a: ack on the edge where the watchdog would fire
    cycle("race_grant", 8'h10, 1'b0);
    for (int k = 0; k < TIMEOUT - 1; k++) cycle("race_wait", 8'h10, 1'b0);
    cycle("race_ack", 8'h02, 1'b1);
    check("race_no_timeout", 32'(bus_if.timeout), 32'd0);
    check("race_valid", 32'(bus_if.grant_valid), 32'd1);
    check("race_sel1", 32'(bus_if.selector), 32'd1);
    cycle("race_drop", 8'h00, 1'b1);

    // 6b: asynchronous reset mid-grant
    cycle("mid_grant", 8'h80, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_selector", 32'(bus_if.selector), 32'd0);
    check("async_grant", 32'(bus_if.grant), 32'h00);
    check("async_valid", 32'(bus_if.grant_valid), 32'd0);
    do_reset(2);
    cycle("restart", 8'hFF, 1'b0);
    check("restart_sel0", 32'(bus_if.selector), 32'd0);
    cycle("restart_drop", 8'h00, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      r = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) r = 8'h00;
      if (i < 300) a = ($urandom_range(0, 1) == 1);
      else         a = ($urandom_range(0, 19) == 0);
      cycle("rand", r, a);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
Round-robin arbiter that sits directly upstream of the 16-bit 8:1 data mux and drives that mux's 3-bit selector. Eight sources raise requests. The arbiter picks one source fairly and holds the selector stable until the downstream consumer acknowledges. A watchdog counter releases a grant that is never acknowledged.

Parameters:
N, 8, number of requesters; fixed to match the 8:1 mux. Not intended to be overridden.
SEL_W, 3, selector width; log2(N).
TIMEOUT, 15, maximum cycles a grant may stay unacknowledged; legal range 1..255.
CNT_W, 8, watchdog counter width; must hold TIMEOUT-1.

Ports:
clk  input  1  rising-edge clock; single clock domain.
rst_n  input  1  asynchronous, active-low reset.
req  input  8  request per source; bit i = source i (mux input i+1).
ack  input  1  downstream has consumed the muxed word; sampled only while grant_valid=1.
selector  output  3  index of the granted source; drives the mux selector directly.
grant  output  8  one-hot copy of selector; all zero when grant_valid=0.
grant_valid  output  1  selector/grant currently valid.
timeout  output  1  one-cycle pulse when a grant is dropped by the watchdog.

Behaviour:
- Reset (rst_n=0, asynchronous): selector=0, grant=0, grant_valid=0, timeout=0, ptr=0, cnt=0, state=IDLE. Deassertion is used synchronously; the first decision is at the first rising edge after release.
- All outputs are registered. No combinational path from req or ack to any output.
- Priority search: scan indices ptr, ptr+1, ..., ptr+7 (mod 8). The first set req bit wins.
- IDLE state:
  - If req != 0 at a rising edge, load selector=winner and grant=1<<winner, set grant_valid=1, cnt=0, go GRANT.
  - Latency from req sampled to grant_valid high is 1 cycle.
  - If req == 0, stay in IDLE; outputs unchanged.
- GRANT state:
  - selector and grant are held constant regardless of req changes. Requesters must hold req until ack; dropping req does not release the grant.
  - ack=1 at an edge:
    - ptr <= selector+1 (mod 8; 7 wraps to 0).
    - Re-search in the same edge using the current req and the new ptr. If a winner exists, load it with grant_valid staying 1 and cnt=0 (back-to-back, no bubble). Otherwise grant_valid=0, grant=0, go IDLE. selector keeps its last value in IDLE.
    - The currently granted source is re-granted only if it is the sole requester.
  - ack=0 and cnt < TIMEOUT-1: cnt <= cnt+1.
  - ack=0 and cnt == TIMEOUT-1 (grant has been held TIMEOUT cycles):
    - grant_valid=0, grant=0, timeout=1 for exactly one cycle.
    - ptr <= selector+1.
    - Go IDLE. No re-grant on this edge; the next grant is decided at the following edge.
  - ack=1 on the same edge where the watchdog would fire: ack wins, timeout stays 0.
- ack while grant_valid=0 is ignored.
- timeout is 0 in every cycle except the pulse cycle.
- Reset mid-grant: all state clears immediately. The interrupted grant is lost and priority restarts at source 0.
- Fairness: with all 8 requesting continuously and ack every cycle, grants cycle 0,1,...,7,0,... Each source waits at most 7 grants.

Test Plan:
1. Reset then idle: rst_n low 3 cycles, req=0 -> selector=0, grant=0x00, grant_valid=0, timeout=0. All stay unchanged for 10 cycles after release.
2. Single request: req=0x20, ack asserted 2 cycles after grant -> grant_valid rises 1 cycle after req, selector=5, grant=0x20. After ack with req=0x00, grant_valid=0 and ptr=6.
3. Round-robin rotation: req=0xFF held, ack=1 every cycle -> selector sequence 0,1,2,3,4,5,6,7,0, grant_valid continuously 1.
4. Wrap and skip: ptr=6 (after granting 5), req=0x05 -> selector=0; after ack -> selector=2; after ack with req=0x04 -> selector=2 re-granted.
5. Watchdog: TIMEOUT=15, req=0x08, ack never asserted -> grant_valid high exactly 15 cycles, then timeout=1 for 1 cycle, grant=0. Next grant goes to source 3 again only if it is the sole requester. With req=0x09 it goes to 0 after wrap from ptr=4.
6. Race and reset: ack=1 on the 15th cycle of a grant -> timeout stays 0 and grant passes normally. Separately, rst_n pulsed low mid-grant -> outputs clear asynchronously before the next clock edge.
